// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter around one shared LC-3 ALU
// Operands are registered on grant; the result is held until its owner consumes it.
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [15:0]      i_req0_a,
   input  logic [15:0]      i_req0_b,
   input  logic [1:0]       i_req0_aluk,
   output logic             o_rsp0_valid,
   input  logic             i_rsp0_ready,
   output logic [15:0]      o_rsp0_data,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [15:0]      i_req1_a,
   input  logic [15:0]      i_req1_b,
   input  logic [1:0]       i_req1_aluk,
   output logic             o_rsp1_valid,
   input  logic             i_rsp1_ready,
   output logic [15:0]      o_rsp1_data,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_grant_cnt0,
   output logic [CNT_W-1:0] o_grant_cnt1
);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_owner;
   logic             r_ptr;
   logic [15:0]      r_a;
   logic [15:0]      r_b;
   logic [1:0]       r_aluk;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic             w_grant_id;
   logic             w_accept;
   logic             w_rsp_fire;
   logic [15:0]      w_alu;

   // Pointer only matters when both requesters compete.
   always_comb begin
      w_grant_id  = (i_req0_valid & i_req1_valid) ? r_ptr : i_req1_valid;
      w_accept    = (r_state == S_IDLE) & (i_req0_valid | i_req1_valid) & i_rst_n;
      w_rsp_fire  = (r_state == S_RESP) & (r_owner ? i_rsp1_ready : i_rsp0_ready);
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)   w_state_nxt = S_RESP;
         S_RESP:  if (w_rsp_fire) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_alu = 16'h0000;
      case (r_aluk)
         2'b00:   w_alu = r_a + r_b;
         2'b01:   w_alu = r_a & r_b;
         2'b10:   w_alu = ~r_a;
         default: w_alu = r_a;
      endcase
   end

   always_comb begin
      o_req0_ready = w_accept & ~w_grant_id;
      o_req1_ready = w_accept & w_grant_id;
      o_rsp0_valid = (r_state == S_RESP) & ~r_owner;
      o_rsp1_valid = (r_state == S_RESP) & r_owner;
      o_rsp0_data  = o_rsp0_valid ? w_alu : 16'h0000;
      o_rsp1_data  = o_rsp1_valid ? w_alu : 16'h0000;
      o_busy       = (r_state == S_RESP);
      o_grant_cnt0 = r_cnt0;
      o_grant_cnt1 = r_cnt1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner <= 1'b0;
         r_ptr   <= 1'b0;
         r_a     <= 16'h0000;
         r_b     <= 16'h0000;
         r_aluk  <= 2'b00;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else if (w_accept) begin
         r_owner <= w_grant_id;
         r_ptr   <= ~w_grant_id;
         r_a     <= w_grant_id ? i_req1_a    : i_req0_a;
         r_b     <= w_grant_id ? i_req1_b    : i_req0_b;
         r_aluk  <= w_grant_id ? i_req1_aluk : i_req0_aluk;
         if (w_grant_id) r_cnt1 <= r_cnt1 + CNT_ONE;
         else            r_cnt0 <= r_cnt0 + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// A second instance with CNT_W=2 shares all inputs to exercise counter wrap.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v0, v1, rr0, rr1;
   logic [15:0] a0, b0, a1, b1;
   logic [1:0]  k0, k1;

   logic        r0, r1, sv0, sv1, busy;
   logic [15:0] d0, d1;
   logic [15:0] c0, c1;
   logic        s_r0, s_r1, s_sv0, s_sv1, s_busy;
   logic [15:0] s_d0, s_d1;
   logic [1:0]  s_c0, s_c1;

   int total = 0;
   int bad   = 0;

   int          m_busy, m_owner, m_ptr, m_cnt0, m_cnt1;
   logic [15:0] m_res;
   logic        last_r0, last_r1, last_v0, last_v1;
   logic [15:0] last_d0, last_d1;

   always #5 clk = ~clk;

   alu_arbiter #(.CNT_W(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_aluk(k0),
      .o_rsp0_valid(sv0), .i_rsp0_ready(rr0), .o_rsp0_data(d0),
      .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_aluk(k1),
      .o_rsp1_valid(sv1), .i_rsp1_ready(rr1), .o_rsp1_data(d1),
      .o_busy(busy), .o_grant_cnt0(c0), .o_grant_cnt1(c1)
   );

   alu_arbiter #(.CNT_W(2)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(v0), .o_req0_ready(s_r0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_aluk(k0),
      .o_rsp0_valid(s_sv0), .i_rsp0_ready(rr0), .o_rsp0_data(s_d0),
      .i_req1_valid(v1), .o_req1_ready(s_r1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_aluk(k1),
      .o_rsp1_valid(s_sv1), .i_rsp1_ready(rr1), .o_rsp1_data(s_d1),
      .o_busy(s_busy), .o_grant_cnt0(s_c0), .o_grant_cnt1(s_c1)
   );

   function automatic logic [15:0] alu_ref(input int a, input int b, input int k);
      case (k)
         0:       return 16'((a + b) % 65536);
         1:       return 16'(a & b);
         2:       return 16'(a ^ 65535);
         default: return 16'(a);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0; m_res = 16'h0000;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic step(output int g);
      int e_g;
      @(negedge clk);
      if (m_busy == 0 && (v0 || v1)) e_g = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
      else e_g = -1;
      last_r0 = r0; last_r1 = r1; last_v0 = sv0; last_v1 = sv1; last_d0 = d0; last_d1 = d1;
      chk("req0_ready", 32'(r0), 32'(e_g == 0));
      chk("req1_ready", 32'(r1), 32'(e_g == 1));
      chk("rsp0_valid", 32'(sv0), 32'(m_busy == 1 && m_owner == 0));
      chk("rsp1_valid", 32'(sv1), 32'(m_busy == 1 && m_owner == 1));
      if (m_busy == 1 && m_owner == 0) chk("rsp0_data", 32'(d0), 32'(m_res));
      if (m_busy == 1 && m_owner == 1) chk("rsp1_data", 32'(d1), 32'(m_res));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_cnt0", 32'(c0), m_cnt0 % 65536);
      chk("grant_cnt1", 32'(c1), m_cnt1 % 65536);
      chk("small_cnt0", 32'(s_c0), m_cnt0 % 4);
      chk("small_cnt1", 32'(s_c1), m_cnt1 % 4);
      if (e_g >= 0) begin
         if (e_g == 0) begin m_cnt0++; m_res = alu_ref(int'(a0), int'(b0), int'(k0)); end
         else          begin m_cnt1++; m_res = alu_ref(int'(a1), int'(b1), int'(k1)); end
         m_ptr   = 1 - e_g;
         m_owner = e_g;
         m_busy  = 1;
      end else if (m_busy == 1 && (m_owner == 1 ? rr1 : rr0)) begin
         m_busy = 0;
      end
      g = e_g;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int order[$];
      int wrap[$];
      logic [15:0] opc_exp [4];
      opc_exp[0] = 16'h0000; opc_exp[1] = 16'h0001; opc_exp[2] = 16'h0000; opc_exp[3] = 16'hFFFF;

      // Reset state, with a request pending to show ready stays low
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; rr0 = 1'b0; rr1 = 1'b0;
      a0 = 16'h0; b0 = 16'h0; k0 = 2'd0; a1 = 16'h0; b1 = 16'h0; k1 = 2'd0;
      model_reset();
      #3;
      chk("rst_req0_ready", 32'(r0), 0);
      chk("rst_req1_ready", 32'(r1), 0);
      chk("rst_rsp0_valid", 32'(sv0), 0);
      chk("rst_rsp1_valid", 32'(sv1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp0_data", 32'(d0), 0);
      chk("rst_rsp1_data", 32'(d1), 0);
      chk("rst_cnt0", 32'(c0), 0);
      chk("rst_cnt1", 32'(c1), 0);
      @(posedge clk); @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;

      // Single op on requester 0
      v0 = 1'b1; a0 = 16'h1234; b0 = 16'h0F0F; k0 = 2'd0;
      step(g);
      chk("single_ready0", 32'(last_r0), 1);
      v0 = 1'b0; a0 = 16'hDEAD; rr0 = 1'b1;
      step(g);
      chk("single_rsp0_valid", 32'(last_v0), 1);
      chk("single_rsp0_data", 32'(last_d0), 32'h2143);
      chk("single_cnt0", 32'(c0), 1);
      rr0 = 1'b0;

      // All opcodes with overflow on requester 1
      for (int k = 0; k < 4; k++) begin
         v1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0001; k1 = 2'(k);
         step(g);
         v1 = 1'b0; rr1 = 1'b1;
         step(g);
         chk($sformatf("opcode%0d_data", k), 32'(last_d1), 32'(opc_exp[k]));
         rr1 = 1'b0;
      end

      // Contention from a fresh reset: expect 0,1,0,1
      do_reset();
      v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
      a0 = 16'($urandom); b0 = 16'($urandom); k0 = 2'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); k1 = 2'($urandom);
      for (int c = 0; c < 8; c++) begin
         step(g);
         if (last_r0) order.push_back(0);
         if (last_r1) order.push_back(1);
         if (g == 0) begin a0 = 16'($urandom); b0 = 16'($urandom); k0 = 2'($urandom); end
         if (g == 1) begin a1 = 16'($urandom); b1 = 16'($urandom); k1 = 2'($urandom); end
      end
      chk("contention_grants", 32'(order.size()), 4);
      for (int i = 0; i < order.size() && i < 4; i++)
         chk($sformatf("contention_order%0d", i), 32'(order[i]), 32'(i % 2));
      chk("contention_cnt0", 32'(c0), 2);
      chk("contention_cnt1", 32'(c1), 2);

      // Backpressure on requester 0 while requester 1 waits
      do_reset();
      v0 = 1'b1; a0 = 16'd5; b0 = 16'd3; k0 = 2'd0;
      step(g);
      v0 = 1'b0; a0 = 16'h7777;
      v1 = 1'b1; a1 = 16'h00F0; b1 = 16'h0F00; k1 = 2'd1;
      for (int c = 0; c < 5; c++) begin
         step(g);
         chk("bp_rsp0_data", 32'(last_d0), 8);
         chk("bp_req1_ready", 32'(last_r1), 0);
      end
      rr0 = 1'b1;
      step(g);
      rr0 = 1'b0;
      step(g);
      chk("bp_then_req1_ready", 32'(last_r1), 1);
      v1 = 1'b0; rr1 = 1'b1;
      step(g);
      chk("bp_rsp1_data", 32'(last_d1), 0);
      rr1 = 1'b0;

      // Asynchronous reset while a result is pending
      v0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; k0 = 2'd0;
      step(g);
      v0 = 1'b0;
      step(g);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_rsp0_valid", 32'(sv0), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_rsp0_data", 32'(d0), 0);
      chk("midrst_cnt0", 32'(c0), 0);
      chk("midrst_cnt1", 32'(c1), 0);
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("midrst_req0_ready", 32'(r0), 0);
      chk("midrst_req1_ready", 32'(r1), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(g);
      chk("midrst_first_grant0", 32'(last_r0), 1);
      chk("midrst_first_grant1", 32'(last_r1), 0);

      // Counter wrap on the CNT_W=2 instance
      do_reset();
      v0 = 1'b1; rr0 = 1'b1;
      for (int c = 0; c < 10; c++) begin
         a0 = 16'($urandom); b0 = 16'($urandom); k0 = 2'($urandom);
         step(g);
         if (last_r0) wrap.push_back(int'(s_c0));
      end
      chk("wrap_grants", 32'(wrap.size()), 5);
      for (int i = 0; i < wrap.size() && i < 5; i++)
         chk($sformatf("wrap_cnt%0d", i), 32'(wrap[i]), (i + 1) % 4);
      chk("wrap_full_cnt0", 32'(c0), 5);

      // Randomized traffic against the model
      do_reset();
      g = -1;
      for (int c = 0; c < 300; c++) begin
         if (!v0 || g == 0) begin
            v0 = ($urandom_range(0, 2) != 0);
            a0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b0 = 16'($urandom); k0 = 2'($urandom);
         end
         if (!v1 || g == 1) begin
            v1 = ($urandom_range(0, 2) != 0);
            a1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b1 = 16'($urandom); k1 = 2'($urandom);
         end
         rr0 = ($urandom_range(0, 3) != 0);
         rr1 = ($urandom_range(0, 3) != 0);
         step(g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
